// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the CPU memory stage and a
// byte-addressed big-endian data RAM. Loads forward from the newest exact
// matching store, stall on partial byte overlap, otherwise read the RAM.
// Drains use the RAM write port whenever no RAM read is in progress.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        St_Valid,
  input  logic [31:0] St_Addr,
  input  logic [31:0] St_Data,
  output logic        St_Ready,
  input  logic        Ld_Valid,
  input  logic [31:0] Ld_Addr,
  output logic [31:0] Ld_Data,
  output logic        Ld_Stall,
  output logic        Empty,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_DataIn,
  output logic        Mem_nRD,
  output logic        Mem_nWR,
  input  logic [31:0] Mem_DataOut
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   addrQ [DEPTH];
  logic [31:0]   dataQ [DEPTH];
  logic [PW-1:0] head, tail, idx;
  logic [CW-1:0] count;

  logic        hit, hitExact, memRead, drain, push, pop;
  logic [31:0] hitData;

  // Two words touch a common byte iff their start addresses are within 3
  // of each other, modulo 2^32.
  function automatic logic overlaps(input logic [31:0] a, input logic [31:0] l);
    logic [31:0] d1, d2;
    d1 = l - a;
    d2 = a - l;
    return (d1 < 32'd4) || (d2 < 32'd4);
  endfunction

  // Scan entries oldest to newest so the last overlapping one wins.
  always_comb begin
    hit      = 1'b0;
    hitExact = 1'b0;
    hitData  = '0;
    idx      = head;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && overlaps(addrQ[idx], Ld_Addr)) begin
        hit      = 1'b1;
        hitExact = (addrQ[idx] == Ld_Addr);
        hitData  = dataQ[idx];
      end
    end
  end

  // Port arbitration and load result; a RAM read takes the port from drain.
  always_comb begin
    memRead    = Ld_Valid && !hit;
    drain      = (count != '0) && !memRead;
    Empty      = (count == '0);
    St_Ready   = (count != CW'(DEPTH));
    push       = St_Valid && St_Ready;
    pop        = drain;
    Mem_nRD    = !memRead;
    Mem_nWR    = !drain;
    Mem_DataIn = Empty ? '0 : dataQ[head];
    Mem_Addr   = memRead ? Ld_Addr : (Empty ? '0 : addrQ[head]);
    Ld_Stall   = Ld_Valid && hit && !hitExact;
    Ld_Data    = '0;
    if (memRead)
      Ld_Data = Mem_DataOut;
    else if (Ld_Valid && hit && hitExact)
      Ld_Data = hitData;
  end

  // Queue storage and pointers; push and pop may occur in the same cycle.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addrQ[i] <= '0;
        dataQ[i] <= '0;
      end
    end else begin
      if (push) begin
        addrQ[tail] <= St_Addr;
        dataQ[tail] <= St_Data;
        tail        <= tail + 1'b1;
      end
      if (pop)
        head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a small big-endian RAM model,
// a write monitor and scoreboard queues for loads and RAM writes.
module tb_store_buffer;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        St_Valid, Ld_Valid;
  logic [31:0] St_Addr, St_Data, Ld_Addr;
  logic        St_Ready, Ld_Stall, Empty, Mem_nRD, Mem_nWR;
  logic [31:0] Ld_Data, Mem_Addr, Mem_DataIn, Mem_DataOut;

  int tests = 0;
  int fails = 0;

  logic [7:0]  ram [256];
  logic [7:0]  ra;
  logic [63:0] wrLog [$];
  logic [63:0] expWr [$];
  logic [31:0] expLd [$];

  store_buffer #(.DEPTH(4)) dut (
    .CLK(CLK), .Reset(Reset),
    .St_Valid(St_Valid), .St_Addr(St_Addr), .St_Data(St_Data), .St_Ready(St_Ready),
    .Ld_Valid(Ld_Valid), .Ld_Addr(Ld_Addr), .Ld_Data(Ld_Data), .Ld_Stall(Ld_Stall),
    .Empty(Empty), .Mem_Addr(Mem_Addr), .Mem_DataIn(Mem_DataIn),
    .Mem_nRD(Mem_nRD), .Mem_nWR(Mem_nWR), .Mem_DataOut(Mem_DataOut)
  );

  always #5 CLK = ~CLK;

  // Big-endian RAM: combinational read, write on negedge.
  assign ra = Mem_Addr[7:0];
  assign Mem_DataOut = {ram[ra], ram[ra + 8'd1], ram[ra + 8'd2], ram[ra + 8'd3]};

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i);
  end

  always @(negedge CLK) begin
    if (!Mem_nWR) begin
      ram[ra]        = Mem_DataIn[31:24];
      ram[ra + 8'd1] = Mem_DataIn[23:16];
      ram[ra + 8'd2] = Mem_DataIn[15:8];
      ram[ra + 8'd3] = Mem_DataIn[7:0];
      wrLog.push_back({Mem_Addr, Mem_DataIn});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input bit expectWrite);
    St_Valid = 1'b1;
    St_Addr  = a;
    St_Data  = d;
    if (expectWrite) expWr.push_back({a, d});
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] expected);
    Ld_Valid = 1'b1;
    Ld_Addr  = a;
    expLd.push_back(expected);
  endtask

  task automatic chkLoad(input string tag);
    chk(tag, 64'(Ld_Data), 64'(expLd.pop_front()));
  endtask

  task automatic chkWrites(input string tag);
    logic [63:0] e, o;
    while (expWr.size() > 0) begin
      e = expWr.pop_front();
      o = (wrLog.size() > 0) ? wrLog.pop_front() : 'x;
      chk(tag, o, e);
    end
    chk({tag, "_extra"}, 64'(wrLog.size()), 64'd0);
    wrLog.delete();
  endtask

  initial begin
    Reset = 1'b1; St_Valid = 1'b0; Ld_Valid = 1'b0;
    St_Addr = '0; St_Data = '0; Ld_Addr = '0;
    #1;
    chk("rst_empty",   64'(Empty),      64'd1);
    chk("rst_ready",   64'(St_Ready),   64'd1);
    chk("rst_nrd",     64'(Mem_nRD),    64'd1);
    chk("rst_nwr",     64'(Mem_nWR),    64'd1);
    chk("rst_stall",   64'(Ld_Stall),   64'd0);
    chk("rst_lddata",  64'(Ld_Data),    64'd0);
    chk("rst_addr",    64'(Mem_Addr),   64'd0);
    chk("rst_datain",  64'(Mem_DataIn), 64'd0);
    tick; tick;
    Reset = 1'b0;

    // Single store drains next cycle, then reads back through RAM.
    tick;
    store(32'h10, 32'h11223344, 1);
    tick;
    St_Valid = 1'b0;
    #1;
    chk("t1_nwr",    64'(Mem_nWR),    64'd0);
    chk("t1_addr",   64'(Mem_Addr),   64'h10);
    chk("t1_datain", 64'(Mem_DataIn), 64'h11223344);
    chk("t1_busy",   64'(Empty),      64'd0);
    tick;
    chk("t1_empty",  64'(Empty),      64'd1);
    chkWrites("t1_wr");
    load(32'h10, 32'h11223344);
    #1;
    chk("t1_ld_nrd", 64'(Mem_nRD), 64'd0);
    chkLoad("t1_ld_data");
    tick;
    Ld_Valid = 1'b0;

    // Forward newest of two same-address stores while RAM reads hold the drain.
    load(32'h40, 32'h40414243);
    store(32'h20, 32'hAAAAAAAA, 1);
    #1;
    chkLoad("t2_ld40_a");
    expLd.push_back(32'h40414243);
    tick;
    store(32'h20, 32'hBBBBBBBB, 1);
    tick;
    St_Valid = 1'b0;
    #1;
    chk("t2_held_nwr", 64'(Mem_nWR), 64'd1);
    chkLoad("t2_ld40_b");
    load(32'h20, 32'hBBBBBBBB);
    #1;
    chkLoad("t2_fwd_data");
    chk("t2_fwd_nrd",   64'(Mem_nRD),  64'd1);
    chk("t2_fwd_stall", 64'(Ld_Stall), 64'd0);
    chk("t2_fwd_nwr",   64'(Mem_nWR),  64'd0);
    tick;
    Ld_Valid = 1'b0;
    tick;
    chk("t2_empty", 64'(Empty), 64'd1);
    chkWrites("t2_wr");

    // Partial overlap stalls until the store drains, then reads merged RAM bytes.
    store(32'h08, 32'h01020304, 1);
    tick;
    St_Valid = 1'b0;
    load(32'h0A, 32'h03040C0D);
    #1;
    chk("t3_stall",   64'(Ld_Stall), 64'd1);
    chk("t3_nrd",     64'(Mem_nRD),  64'd1);
    chk("t3_lddata0", 64'(Ld_Data),  64'd0);
    for (int n = 0; n < 8 && Ld_Stall; n++) tick;
    chk("t3_unstall", 64'(Ld_Stall), 64'd0);
    chk("t3_rd_nrd",  64'(Mem_nRD),  64'd0);
    chkLoad("t3_merged");
    tick;
    Ld_Valid = 1'b0;
    chkWrites("t3_wr");

    // Fill while loads hold the port; fifth store is dropped.
    Ld_Valid = 1'b1;
    Ld_Addr  = 32'h80;
    for (int i = 0; i < 4; i++) begin
      store(32'h50 + 32'(4 * i), 32'hA0000001 + 32'(i), 1);
      tick;
    end
    St_Valid = 1'b0;
    expLd.push_back(32'h80818283);
    #1;
    chk("t4_full",     64'(St_Ready), 64'd0);
    chk("t4_held_nwr", 64'(Mem_nWR),  64'd1);
    chkLoad("t4_ld80");
    store(32'h60, 32'hDEADBEEF, 0);
    tick;
    St_Valid = 1'b0;
    chk("t4_still_full", 64'(St_Ready), 64'd0);
    Ld_Valid = 1'b0;
    #1;
    chk("t4_drain_nwr",  64'(Mem_nWR),  64'd0);
    chk("t4_drain_addr", 64'(Mem_Addr), 64'h50);
    for (int i = 0; i < 4; i++) tick;
    chk("t4_empty", 64'(Empty),    64'd1);
    chk("t4_ready", 64'(St_Ready), 64'd1);
    chkWrites("t4_wr");

    // Reset while draining discards everything immediately.
    Ld_Valid = 1'b1;
    Ld_Addr  = 32'h80;
    for (int i = 0; i < 3; i++) begin
      store(32'h90 + 32'(4 * i), 32'hC0000000 + 32'(i), 0);
      tick;
    end
    St_Valid = 1'b0;
    Ld_Valid = 1'b0;
    #1;
    chk("t5_nwr_pre", 64'(Mem_nWR), 64'd0);
    Reset = 1'b1;
    #1;
    chk("t5_nwr_rst",   64'(Mem_nWR), 64'd1);
    chk("t5_empty_rst", 64'(Empty),   64'd1);
    tick;
    Reset = 1'b0;
    tick; tick;
    chk("t5_nwr_post", 64'(Mem_nWR), 64'd1);
    chkWrites("t5_wr");

    // Same-cycle store and load to one address: load sees old RAM data.
    store(32'h30, 32'h00000005, 1);
    load(32'h30, 32'h30313233);
    #1;
    chkLoad("t6_old");
    chk("t6_nrd", 64'(Mem_nRD), 64'd0);
    tick;
    St_Valid = 1'b0;
    Ld_Valid = 1'b0;
    #1;
    chk("t6_nwr",    64'(Mem_nWR),    64'd0);
    chk("t6_addr",   64'(Mem_Addr),   64'h30);
    chk("t6_datain", 64'(Mem_DataIn), 64'h5);
    tick;
    chk("t6_empty", 64'(Empty), 64'd1);
    chkWrites("t6_wr");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the CPU memory stage and the byte-addressed, big-endian data RAM. Stores are queued in a small FIFO and drained into the RAM's write port one per cycle. Loads are served in the same cycle, either forwarded from the newest matching queued store or read through the RAM's combinational read path. Byte-overlap hazards between a load and a queued store stall the load until the store drains.

## Interface
- DEPTH, 4, number of store entries (power of two, ≥2)
- CLK  in  1  clock; all state updates on posedge
- Reset  in  1  asynchronous, active-high
- St_Valid  in  1  store request this cycle
- St_Addr  in  32  store byte address (need not be word-aligned)
- St_Data  in  32  store data, [31:24] goes to St_Addr, [7:0] to St_Addr+3
- St_Ready  out  1  buffer can accept a store (not full)
- Ld_Valid  in  1  load request this cycle
- Ld_Addr  in  32  load byte address
- Ld_Data  out  32  load result, valid when Ld_Valid=1 and Ld_Stall=0
- Ld_Stall  out  1  load cannot complete this cycle; CPU holds Ld_Valid/Ld_Addr
- Empty  out  1  no queued stores (fence/halt condition)
- Mem_Addr  out  32  RAM Address
- Mem_DataIn  out  32  RAM DataIn
- Mem_nRD  out  1  RAM read enable, active-low
- Mem_nWR  out  1  RAM write enable, active-low (RAM writes on negedge CLK)
- Mem_DataOut  in  32  RAM DataOut

## Operation
- State: DEPTH entries {addr, data}, head/tail pointers (wrap modulo DEPTH), count 0..DEPTH.
- Push: on posedge with St_Valid=1 and St_Ready=1, write the entry at tail, tail+1, count+1. When St_Ready=0, St_Valid is ignored with no state change. St_Ready is !full from registered count. There is no push-through when full even if a pop occurs that cycle.
- Overlap test per valid entry with address A against load address L: overlap if (L−A) mod 2^32 < 4 or (A−L) mod 2^32 < 4. Exact if A==L.
- Load resolution, Ld_Valid=1, combinational:
  - Find the newest (closest to tail) overlapping entry.
  - None: RAM read. Mem_nRD=0, Mem_Addr=Ld_Addr, Ld_Data=Mem_DataOut, Ld_Stall=0.
  - Newest overlapping entry is exact: forward. Ld_Data=entry data, Mem_nRD=1, Ld_Stall=0.
  - Otherwise (partial overlap): Ld_Stall=1, Mem_nRD=1, Ld_Data=0.
- Drain: when count≠0 and no RAM read is in progress this cycle, assert Mem_nWR=0 with Mem_Addr=head.addr and Mem_DataIn=head.data. On the next posedge, head+1 and count−1.
- Port priority: a RAM read beats a drain. Forwarded and stalled loads do not use the port, so the drain proceeds.
- Idle defaults: Mem_nRD=1, Mem_nWR=1, Mem_Addr=head.addr (0 when empty), Mem_DataIn=head.data, Ld_Data=0, Ld_Stall=0.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Simultaneous St_Valid and Ld_Valid: both are served. The load resolves against entries present at the start of the cycle and never sees the same-cycle store.
- Ld_Stall is never asserted when Ld_Valid=0.

## Timing
- Reset (async): head=tail=count=0. Outputs: Empty=1, St_Ready=1, Mem_nRD=1, Mem_nWR=1, Ld_Stall=0, Ld_Data=0, Mem_Addr=0, Mem_DataIn=0.
- Store accepted at edge N: earliest RAM write is in cycle N+1 (Mem_nWR low), committed at the negedge of N+1. The entry retires at edge N+2.
- Load latency is 0 cycles, combinational from Ld_Addr, Mem_DataOut and entry state.
- A stalled load completes within count cycles, provided no further loads to the RAM block drains.
- Reset mid-drain discards all queued stores. Mem_nWR deasserts immediately, asynchronously.
- Throughput: 1 store/cycle in and 1 drain/cycle out when there are no RAM reads.

## Test plan
- Reset, then push 0x00000010←0x11223344. Mem_nWR=0, Mem_Addr=0x10, Mem_DataIn=0x11223344 in the next cycle, then Empty=1. A later load of 0x10 returns 0x11223344 via the RAM.
- Push 0x20←0xAAAAAAAA then 0x20←0xBBBBBBBB, and hold the drain with RAM loads to 0x40. A load of 0x20 forwards 0xBBBBBBBB, Mem_nRD=1, Ld_Stall=0.
- Queue 0x08←0x01020304, then load 0x0A. Ld_Stall=1 until the entry drains, then Ld_Data = RAM bytes {01 at 0x0A? no: 0x03,0x04,RAM[0x0C],RAM[0x0D]}, Mem_nRD=0.
- Fill DEPTH=4 while continuous loads block the drain. St_Ready=0, a 5th store is ignored. After the loads stop, 4 drain cycles in FIFO order with pointer wrap, then Empty=1 and St_Ready=1.
- Assert Reset with 3 entries queued and Mem_nWR=0. Mem_nWR=1 immediately, Empty=1, no further RAM writes.
- Same cycle: St_Valid 0x30←0x5 and Ld_Valid 0x30 with the buffer empty. The load returns old RAM data, the store drains the next cycle.
